// File: rtl/reaction_game_ctrl.sv
// Reflex-game round sequencer: random pre-start wait, GO, BCD millisecond count, result/foul display.
// Optional best-time tracking is enabled by defining REACTION_BEST_EN.
module reaction_game_ctrl #(
    parameter int unsigned TICK_DIV       = 100000,
    parameter int unsigned MIN_WAIT_MS    = 1000,
    parameter int unsigned WAIT_RAND_BITS = 11
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_btn,
    input  logic       react_btn,
    output logic [3:0] dig3,
    output logic [3:0] dig2,
    output logic [3:0] dig1,
    output logic [3:0] dig0,
    output logic       go_led,
    output logic       foul_led,
    output logic       timeout,
    output logic [2:0] state,
    output logic       new_best
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_WAIT   = 3'd1,
        S_GO     = 3'd2,
        S_RESULT = 3'd3,
        S_FOUL   = 3'd4
    } state_t;

    localparam int unsigned DIV_W     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [15:0] RAND_MASK = 16'((32'd1 << WAIT_RAND_BITS) - 32'd1);

    state_t             state_q;
    logic [2:0]         start_sync_q;
    logic [2:0]         react_sync_q;
    logic [15:0]        lfsr_q;
    logic [DIV_W-1:0]   div_q;
    logic [15:0]        wait_cnt_q;
    logic [15:0]        digits_q;
    logic               go_led_q;
    logic               foul_led_q;
    logic               timeout_q;

    logic               start_edge;
    logic               react_edge;
    logic               tick;
    logic [15:0]        lfsr_d;
    logic [15:0]        wait_load;
    logic [15:0]        digits_inc;
    logic [15:0]        idle_digits;

    // Index 1 is the second synchroniser stage; index 2 is its delayed copy for edge detection.
    assign start_edge = start_sync_q[1] & ~start_sync_q[2];
    assign react_edge = react_sync_q[1] & ~react_sync_q[2];
    assign tick       = (div_q == DIV_W'(TICK_DIV - 1));
    assign lfsr_d     = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
    assign wait_load  = 16'(MIN_WAIT_MS) + (lfsr_q & RAND_MASK);

    always_comb begin
        logic carry;
        digits_inc = digits_q;
        carry      = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (carry) begin
                if (digits_q[4*i +: 4] == 4'd9) begin
                    digits_inc[4*i +: 4] = 4'd0;
                end else begin
                    digits_inc[4*i +: 4] = digits_q[4*i +: 4] + 4'd1;
                    carry                = 1'b0;
                end
            end
        end
    end

`ifdef REACTION_BEST_EN
    logic [13:0] best_q;
    logic        new_best_q;
    logic [13:0] time_bin;

    assign time_bin = 14'(digits_q[15:12]) * 14'd1000 + 14'(digits_q[11:8]) * 14'd100
                    + 14'(digits_q[7:4]) * 14'd10 + 14'(digits_q[3:0]);
    assign idle_digits = {4'(best_q / 14'd1000), 4'((best_q / 14'd100) % 14'd10),
                          4'((best_q / 14'd10) % 14'd10), 4'(best_q % 14'd10)};
    assign new_best = new_best_q;
`else
    assign idle_digits = 16'h0000;
    assign new_best    = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            start_sync_q <= '0;
            react_sync_q <= '0;
            lfsr_q       <= 16'hACE1;
            div_q        <= '0;
            wait_cnt_q   <= '0;
            digits_q     <= '0;
            go_led_q     <= 1'b0;
            foul_led_q   <= 1'b0;
            timeout_q    <= 1'b0;
`ifdef REACTION_BEST_EN
            best_q       <= 14'd9999;
            new_best_q   <= 1'b0;
`endif
        end else begin
            start_sync_q <= {start_sync_q[1:0], start_btn};
            react_sync_q <= {react_sync_q[1:0], react_btn};
            lfsr_q       <= lfsr_d;
            div_q        <= tick ? '0 : div_q + 1'b1;
`ifdef REACTION_BEST_EN
            new_best_q   <= 1'b0;
`endif
            case (state_q)
                S_IDLE: begin
                    digits_q <= idle_digits;
                    if (start_edge) begin
                        state_q    <= S_WAIT;
                        wait_cnt_q <= wait_load;
                        div_q      <= '0;
                        digits_q   <= '0;
                    end
                end
                S_WAIT: begin
                    if (react_edge) begin
                        state_q    <= S_FOUL;
                        foul_led_q <= 1'b1;
                        digits_q   <= '0;
                    end else if (tick) begin
                        if (wait_cnt_q <= 16'd1) begin
                            state_q  <= S_GO;
                            go_led_q <= 1'b1;
                            div_q    <= '0;
                            digits_q <= '0;
                        end else begin
                            wait_cnt_q <= wait_cnt_q - 16'd1;
                        end
                    end
                end
                S_GO: begin
                    if (react_edge) begin
                        state_q  <= S_RESULT;
                        go_led_q <= 1'b0;
`ifdef REACTION_BEST_EN
                        if (time_bin < best_q) begin
                            best_q     <= time_bin;
                            new_best_q <= 1'b1;
                        end
`endif
                    end else if (tick) begin
                        // The tick that would roll past 9999 saturates instead and ends the round.
                        if (digits_q == 16'h9999) begin
                            state_q   <= S_RESULT;
                            go_led_q  <= 1'b0;
                            timeout_q <= 1'b1;
                        end else begin
                            digits_q <= digits_inc;
                        end
                    end
                end
                S_RESULT, S_FOUL: begin
                    if (start_edge) begin
                        state_q    <= S_WAIT;
                        foul_led_q <= 1'b0;
                        timeout_q  <= 1'b0;
                        wait_cnt_q <= wait_load;
                        div_q      <= '0;
                        digits_q   <= '0;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign state    = state_q;
    assign dig3     = digits_q[15:12];
    assign dig2     = digits_q[11:8];
    assign dig1     = digits_q[7:4];
    assign dig0     = digits_q[3:0];
    assign go_led   = go_led_q;
    assign foul_led = foul_led_q;
    assign timeout  = timeout_q;

endmodule

// File: tb/tb_reaction_game_ctrl.sv
// Directed/randomised bench for reaction_game_ctrl with a millisecond-level reference model.
module tb_reaction_game_ctrl;

    localparam int T    = 3;
    localparam int MINW = 5;
    localparam logic [15:0] RMASK = 16'h0003;
`ifdef REACTION_BEST_EN
    localparam bit BEST_EN = 1'b1;
`else
    localparam bit BEST_EN = 1'b0;
`endif
    localparam logic [2:0] ST_IDLE = 3'd0, ST_WAIT = 3'd1, ST_GO = 3'd2, ST_RESULT = 3'd3, ST_FOUL = 3'd4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start_btn = 1'b0;
    logic react_btn = 1'b0;
    logic [3:0] dig3, dig2, dig1, dig0;
    logic go_led, foul_led, timeout, new_best;
    logic [2:0] state;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int w_ms, w_cyc, g_cyc;
    int m_best = 9999;
    logic [15:0] m_lfsr, m_lfsr_prev;
    logic [15:0] idle_exp;

    reaction_game_ctrl #(.TICK_DIV(T), .MIN_WAIT_MS(MINW), .WAIT_RAND_BITS(2)) dut (
        .clk(clk), .rst(rst), .start_btn(start_btn), .react_btn(react_btn),
        .dig3(dig3), .dig2(dig2), .dig1(dig1), .dig0(dig0),
        .go_led(go_led), .foul_led(foul_led), .timeout(timeout),
        .state(state), .new_best(new_best)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Galois LFSR for polynomial x^16+x^14+x^13+x^11+1, right-shifting.
    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        logic [15:0] s;
        s = v >> 1;
        if (v[0]) s = s ^ 16'hB400;
        return s;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_lfsr      <= 16'hACE1;
            m_lfsr_prev <= 16'hACE1;
        end else begin
            m_lfsr_prev <= m_lfsr;
            m_lfsr      <= lfsr_step(m_lfsr);
        end
    end

    function automatic logic [15:0] to_bcd(input int v);
        return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic logic [22:0] pack(input logic [2:0] st, input bit go, input bit fl,
                                         input bit to, input bit nb, input logic [15:0] d);
        return {st, go, fl, to, nb, d};
    endfunction

    function automatic logic [22:0] obs();
        return {state, go_led, foul_led, timeout, new_best, dig3, dig2, dig1, dig0};
    endfunction

    task automatic check(input string tag, input logic [22:0] o, input logic [22:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h (state,go,foul,timeout,new_best,digits)", tag, o, e);
        end
    endtask

    task automatic enter_wait(input logic [2:0] from_st, input bit with_react, input bit hold_start);
        start_btn = 1'b1;
        react_btn = with_react;
        @(negedge clk);
        @(negedge clk);
        check("pre_start_state", {20'd0, state}, {20'd0, from_st});
        @(negedge clk);
        w_ms  = MINW + int'(m_lfsr_prev & RMASK);
        w_cyc = cyc;
        check("enter_wait", obs(), pack(ST_WAIT, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000));
        start_btn = hold_start;
        react_btn = 1'b0;
        $display("start (react=%0b) from state %0d -> WAIT, expecting %0d ms", with_react, from_st, w_ms);
    endtask

    task automatic wait_to_go();
        while (cyc - w_cyc < w_ms * T - 1) @(negedge clk);
        check("wait_last_cycle", obs(), pack(ST_WAIT, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000));
        @(negedge clk);
        g_cyc = cyc;
        check("enter_go", obs(), pack(ST_GO, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000));
        $display("WAIT of %0d ms elapsed -> GO", w_ms);
    endtask

    task automatic react_at(input int d);
        int ms;
        bit nb;
        logic [22:0] res;
        while (cyc - g_cyc < d) @(negedge clk);
        check("go_count", obs(), pack(ST_GO, 1'b1, 1'b0, 1'b0, 1'b0, to_bcd(d / T)));
        react_btn = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("go_before_react", obs(), pack(ST_GO, 1'b1, 1'b0, 1'b0, 1'b0, to_bcd((d + 2) / T)));
        @(negedge clk);
        ms = (d + 2) / T;
        nb = BEST_EN && (ms < m_best);
        if (nb) m_best = ms;
        res = pack(ST_RESULT, 1'b0, 1'b0, 1'b0, 1'b0, to_bcd(ms));
        check("result", obs(), pack(ST_RESULT, 1'b0, 1'b0, 1'b0, nb, to_bcd(ms)));
        react_btn = 1'b0;
        $display("react %0d clk into GO -> RESULT %0d ms, new_best=%0b", d + 3, ms, nb);
        repeat (20) @(negedge clk);
        check("result_hold", obs(), res);
        react_btn = 1'b1;
        repeat (5) @(negedge clk);
        react_btn = 1'b0;
        repeat (3) @(negedge clk);
        check("result_react_ignored", obs(), res);
    endtask

    task automatic foul_in_wait(input bit with_start);
        int k;
        k = $urandom_range(3, w_ms * T - 4);
        while (cyc - w_cyc < k) @(negedge clk);
        react_btn = 1'b1;
        if (with_start) start_btn = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("wait_before_foul", obs(), pack(ST_WAIT, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000));
        @(negedge clk);
        check("foul", obs(), pack(ST_FOUL, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000));
        react_btn = 1'b0;
        if (with_start) start_btn = 1'b0;
        $display("react (start=%0b) %0d clk into WAIT -> FOUL", with_start, k + 3);
        repeat (8) @(negedge clk);
        check("foul_hold", obs(), pack(ST_FOUL, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000));
    endtask

    initial begin
        idle_exp = BEST_EN ? 16'h9999 : 16'h0000;

        // Reset and idle
        repeat (3) @(negedge clk);
        check("in_reset", obs(), pack(ST_IDLE, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000));
        rst = 1'b1;
        repeat (4) @(negedge clk);
        check("idle_after_reset", obs(), pack(ST_IDLE, 1'b0, 1'b0, 1'b0, 1'b0, idle_exp));
        $display("reset released -> IDLE");

        // First round: a start pulse during WAIT must not disturb the countdown
        enter_wait(ST_IDLE, 1'b0, 1'b0);
        repeat (4) @(negedge clk);
        start_btn = 1'b1;
        repeat (3) @(negedge clk);
        start_btn = 1'b0;
        wait_to_go();
        react_at(25 * T - 2);

        // Random rounds, one with a start pulse in GO
        for (int r = 0; r < 4; r++) begin
            enter_wait(ST_RESULT, 1'b0, 1'b0);
            wait_to_go();
            if (r == 0) begin
                repeat (2) @(negedge clk);
                start_btn = 1'b1;
                repeat (3) @(negedge clk);
                start_btn = 1'b0;
                react_at(10 + $urandom_range(0, 40 * T));
            end else begin
                react_at($urandom_range(0, 40 * T));
            end
        end

        // React edge coinciding with the tick that would make 0042
        enter_wait(ST_RESULT, 1'b0, 1'b0);
        wait_to_go();
        react_at(42 * T - 3);

        // Fouls; start wins over react outside WAIT/GO; start+react inside WAIT fouls
        enter_wait(ST_RESULT, 1'b0, 1'b0);
        foul_in_wait(1'b0);
        enter_wait(ST_FOUL, 1'b1, 1'b0);
        repeat (4) @(negedge clk);
        foul_in_wait(1'b1);

        // Start held high across the foul produces no second edge
        enter_wait(ST_FOUL, 1'b0, 1'b1);
        foul_in_wait(1'b0);
        repeat (20) @(negedge clk);
        start_btn = 1'b0;
        repeat (5) @(negedge clk);
        check("held_start_single_edge", obs(), pack(ST_FOUL, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000));

        // Never react: count saturates at 9999 with timeout
        enter_wait(ST_FOUL, 1'b0, 1'b0);
        wait_to_go();
        while (cyc - g_cyc < 10000 * T) begin
            check("go_running", obs(), pack(ST_GO, 1'b1, 1'b0, 1'b0, 1'b0, to_bcd((cyc - g_cyc) / T)));
            @(negedge clk);
        end
        check("timeout", obs(), pack(ST_RESULT, 1'b0, 1'b0, 1'b1, 1'b0, 16'h9999));
        $display("no react for %0d clk -> RESULT 9999 with timeout", 10000 * T);
        repeat (5) @(negedge clk);
        enter_wait(ST_RESULT, 1'b0, 1'b0);

        // Reset in the middle of GO
        wait_to_go();
        repeat ($urandom_range(5, 50)) @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset_mid_go", obs(), pack(ST_IDLE, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000));
        @(negedge clk);
        rst = 1'b1;
        m_best = 9999;
        @(negedge clk);
        check("idle_after_mid_reset", obs(), pack(ST_IDLE, 1'b0, 1'b0, 1'b0, 1'b0, idle_exp));
        $display("reset during GO -> IDLE");

        // Rounds of 30, 20, 25 ms after reset
        enter_wait(ST_IDLE, 1'b0, 1'b0);
        wait_to_go();
        react_at(30 * T - 2);
        enter_wait(ST_RESULT, 1'b0, 1'b0);
        wait_to_go();
        react_at(20 * T - 2);
        enter_wait(ST_RESULT, 1'b0, 1'b0);
        wait_to_go();
        react_at(25 * T - 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
